// File: rtl/pmod_da4_sample_feeder.sv
// Sample feeder for the PMOD DA4 SPI master: FIFO-buffers samples and issues one st_wrt per rate tick.
// Optional PMOD_DA4_HOLD_LAST_EN: an underrun tick re-sends the last dac_data (midscale after reset).
module pmod_da4_sample_feeder #(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 8,
  parameter int RATE_DIV = 1000
) (
  input  logic                     clk100mhz,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     st_wrt,
  output logic [DATA_W-1:0]        dac_data,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     underrun,
  output logic                     tick_missed,
  input  logic                     clear_flags
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int DIV_W = $clog2(RATE_DIV);
`ifdef PMOD_DA4_HOLD_LAST_EN
  localparam logic [DATA_W-1:0] DAC_RST = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] DAC_RST = '0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   dac_q;
  logic                in_ready_q, done_q, underrun_q, underrun_d, missed_q;
  logic                tick, done_rise, push, pop;

  assign tick      = enable && (div_q == DIV_W'(RATE_DIV - 1));
  assign done_rise = done && !done_q;
  assign push      = in_valid && in_ready_q;

  always_comb begin
    div_d = div_q;
    if (!enable)   div_d = '0;
    else if (tick) div_d = '0;
    else           div_d = div_q + DIV_W'(1);
  end

  // A pop only happens on an IDLE tick with data, so it never needs to see this cycle's push.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    st_wrt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            underrun_d = 1'b1;
`ifdef PMOD_DA4_HOLD_LAST_EN
            state_d    = ISSUE;
`endif
          end
        end
      end
      ISSUE: begin
        st_wrt  = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (done_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dac_q      <= DAC_RST;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != CNT_W'(DEPTH));
      done_q     <= done;
      underrun_q <= underrun_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dac_q    <= mem_q[rd_ptr_q];
      end
      // Set has priority over clear.
      if (tick && state_q == BUSY) missed_q <= 1'b1;
      else if (clear_flags)        missed_q <= 1'b0;
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready    = in_ready_q;
  assign dac_data    = dac_q;
  assign fifo_count  = count_q;
  assign underrun    = underrun_q;
  assign tick_missed = missed_q;

endmodule

// File: tb/tb_pmod_da4_sample_feeder.sv
// Bench for pmod_da4_sample_feeder: directed scenarios plus random traffic against a queue-based reference model.
module tb_pmod_da4_sample_feeder;
  localparam int DATA_W = 12, DEPTH = 4, RATE_DIV = 20;
`ifdef PMOD_DA4_HOLD_LAST_EN
  localparam logic [DATA_W-1:0] RST_DAC = 12'h800;
`else
  localparam logic [DATA_W-1:0] RST_DAC = 12'h000;
`endif

  logic              clk100mhz = 1'b0, rst_n = 1'b0, enable = 1'b0, in_valid = 1'b0, clear_flags = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              done, in_ready, st_wrt, underrun, tick_missed;
  logic [DATA_W-1:0] dac_data;
  logic [2:0]        fifo_count;

  always #5 clk100mhz = ~clk100mhz;

  pmod_da4_sample_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RATE_DIV(RATE_DIV)) dut (
    .clk100mhz(clk100mhz), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .st_wrt(st_wrt), .dac_data(dac_data), .done(done), .fifo_count(fifo_count),
    .underrun(underrun), .tick_missed(tick_missed), .clear_flags(clear_flags)
  );

  // SPI master stand-in: done rises done_delay cycles after st_wrt, held for 2 cycles.
  int done_delay = 50;
  int dcnt = 0;
  always @(negedge clk100mhz or negedge rst_n) begin
    if (!rst_n)                                dcnt <= 0;
    else if (st_wrt)                           dcnt <= 1;
    else if (dcnt != 0 && dcnt <= done_delay + 1) dcnt <= dcnt + 1;
    else                                       dcnt <= 0;
  end
  assign done = (dcnt >= done_delay) && (dcnt <= done_delay + 1);

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sample queue, enable-cycle phase, and transfer bookkeeping.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dac;
  int  m_phase;
  bit  m_issue, m_busy, m_missed, m_underrun, m_ready, m_done_prev, m_push;
  logic [DATA_W-1:0] obs[$];

  task model_reset();
    m_q.delete();
    m_phase = 0; m_issue = 0; m_busy = 0; m_missed = 0; m_underrun = 0;
    m_ready = 0; m_done_prev = 0; m_push = 0; m_dac = RST_DAC;
  endtask

  task model_step();
    bit tick, drise;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick        = enable && (m_phase == RATE_DIV - 1);
    m_phase     = enable ? (m_phase + 1) % RATE_DIV : 0;
    drise       = done && !m_done_prev;
    m_done_prev = done;
    m_push      = in_valid && m_ready;
    m_underrun  = 0;
    if (m_busy && tick)   m_missed = 1;
    else if (clear_flags) m_missed = 0;
    if (m_issue) begin
      m_issue = 0;
      m_busy  = 1;
    end else if (m_busy) begin
      if (drise) m_busy = 0;
    end else if (tick) begin
      if (m_q.size() != 0) begin
        m_dac   = m_q.pop_front();
        m_issue = 1;
      end else begin
        m_underrun = 1;
`ifdef PMOD_DA4_HOLD_LAST_EN
        m_issue = 1;
`endif
      end
    end
    if (m_push) m_q.push_back(in_data);
    m_ready = (m_q.size() != DEPTH);
  endtask

  task check_all();
    chk("st_wrt", st_wrt, m_issue);
    chk("dac_data", dac_data, m_dac);
    chk("fifo_count", fifo_count, m_q.size());
    chk("in_ready", in_ready, m_ready);
    chk("underrun", underrun, m_underrun);
    chk("tick_missed", tick_missed, m_missed);
  endtask

  task step();
    @(posedge clk100mhz);
    model_step();
    @(negedge clk100mhz);
    check_all();
    if (st_wrt) obs.push_back(dac_data);
  endtask

  task run(input int n);
    repeat (n) step();
  endtask

  task send(input logic [DATA_W-1:0] v);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = m_push;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
  endtask

  logic [DATA_W-1:0] t1_exp[3] = '{12'hAAA, 12'h555, 12'h123};
  logic [DATA_W-1:0] t2_exp[6];

  initial begin
    bit seen;
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(2);

    // Three samples paced out in order
    foreach (t1_exp[i]) send(t1_exp[i]);
    obs.delete();
    enable = 1'b1;
    run(300);
    chk("t1_issues", obs.size(), 3);
    foreach (t1_exp[i]) chk("t1_order", (i < obs.size()) ? obs[i] : 12'hFFF, t1_exp[i]);

    // Back-pressure at full, then drain
    enable = 1'b0;
    run(80);
    foreach (t2_exp[i]) t2_exp[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) send(t2_exp[i]);
    in_valid = 1'b1; in_data = t2_exp[4];
    run(3);
    chk("t2_full_ready", in_ready, 0);
    chk("t2_full_count", fifo_count, 4);
    obs.delete();
    enable = 1'b1;
    send(t2_exp[4]);
    send(t2_exp[5]);
    run(400);
    chk("t2_issues", obs.size(), 6);
    foreach (t2_exp[i]) chk("t2_order", (i < obs.size()) ? obs[i] : 12'hFFF, t2_exp[i]);

    // Empty FIFO: underrun ticks
    run(100);

    // Slow done: ticks during transfer are flagged, then cleared
    done_delay = 30;
    send(12'h3C3);
    send(12'h0F0);
    run(150);
    chk("t4_missed", tick_missed, 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    run(100);

    // Reset in the middle of a transfer
    done_delay = 50;
    enable = 1'b0;
    run(80);
    send(12'h777);
    send(12'h888);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = st_wrt;
    end
    chk("t5_issue_seen", seen, 1);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_st_wrt", st_wrt, 0);
    chk("t5_rst_dac", dac_data, RST_DAC);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_missed", tick_missed, 0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(60);
    send(12'h246);
    run(150);

    // Push+pop at count 2, then full FIFO refusing a push on a pop cycle
    enable = 1'b0;
    do_reset();
    run(2);
    send(12'h111);
    send(12'h222);
    enable = 1'b1;
    run(RATE_DIV - 1);
    in_valid = 1'b1; in_data = 12'h333;
    step();
    in_valid = 1'b0;
    chk("t6_pushpop_count", fifo_count, 2);
    enable = 1'b0;
    send(12'h444);
    send(12'h555);
    run(80);
    chk("t6_full_count", fifo_count, 4);
    enable = 1'b1;
    run(RATE_DIV - 1);
    in_valid = 1'b1; in_data = 12'h666;
    step();
    in_valid = 1'b0;
    chk("t6_refused_count", fifo_count, 3);
    run(50);

    // Random traffic
    for (int seg = 0; seg < 20; seg++) begin
      enable = ($urandom_range(0, 3) != 0);
      if (!m_busy && !m_issue) done_delay = $urandom_range(3, 60);
      for (int c = 0; c < 80; c++) begin
        in_valid    = ($urandom_range(0, 2) == 0);
        in_data     = DATA_W'($urandom);
        clear_flags = ($urandom_range(0, 30) == 0);
        step();
      end
    end
    in_valid = 1'b0;
    clear_flags = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
